sd_cmd_scheduler: RTL and testbench
===================================

// Module: sd_cmd_scheduler
// PURPOSE
//  Shares the SD physical command channel between NUM_REQ requesters (host command controller, data/DMA path).
//  Round-robin grant; latches and issues the winner's 48-bit command; collects the response or timeout.
//  Retries timed-out commands up to MAX_RETRY times, then returns the response/error to the granted requester.
//  Sits between the command-layer requesters and the physical command control block.
// PARAMETERS
//  NUM_REQ    2    number of requesters (2..4)
//  CMD_W      48   command/response width
//  MAX_RETRY  2    re-issues after a timeout before reporting error
//  RETRY_GAP  4    idle cycles between a timeout and the re-issue
//  WATCHDOG   128  cycles in S_WAIT with no response/timeout before local abort (must exceed phy timeout of 60)
// PORTS
//  iClock_SD           in   1              SD clock, all logic on posedge
//  iReset              in   1              synchronous, active-high
//  iReq                in   NUM_REQ        request level per requester, held until oDone seen
//  iCommand_bus        in   NUM_REQ*CMD_W  requester k's command at [k*CMD_W +: CMD_W]
//  oGrant              out  NUM_REQ        one-hot, active from S_ARB until S_RELEASE exits
//  oDone               out  NUM_REQ        one-cycle pulse to granted requester; oResponse/oError valid
//  oResponse           out  CMD_W          latched response, held until next S_DONE
//  oError              out  1              with oDone: retries exhausted or watchdog abort
//  oStrobe_to_phy      out  1              one-cycle command strobe to phy
//  oCommand_to_phy     out  CMD_W          latched command, stable from S_ISSUE through S_WAIT
//  iStrobe_from_phy    in   1              phy response ready
//  iResponse_from_phy  in   CMD_W          phy response, valid with iStrobe_from_phy
//  iTimeout_from_phy   in   1              phy command timeout pulse
//  oAck_to_phy         out  1              one-cycle response acknowledge
//  oIdle_to_phy        out  1              one-cycle force-idle to phy on watchdog abort
// BEHAVIOUR
//  Reset: all outputs 0, state S_IDLE, RR pointer=0, retry/watchdog counters 0. Reset at any state aborts; no oDone.
//  States and transitions (one per clock):
//   S_IDLE    : any iReq -> S_ARB; else stay.
//   S_ARB     : pick first set iReq at/after pointer (wrap); set oGrant; latch its command -> S_ISSUE.
//   S_ISSUE   : oStrobe_to_phy=1 one cycle; clear watchdog -> S_WAIT.
//   S_WAIT    : iStrobe_from_phy -> latch response, S_ACK (wins over simultaneous timeout).
//               iTimeout_from_phy: retry<MAX_RETRY -> retry++, S_GAP; else oError, S_DONE.
//               watchdog==WATCHDOG-1 -> oIdle_to_phy=1, oError, S_DONE.
//   S_GAP     : count RETRY_GAP cycles -> S_ISSUE (same latched command).
//   S_ACK     : oAck_to_phy=1 one cycle -> S_DONE.
//   S_DONE    : oDone[g]=1 one cycle; pointer=g+1 mod NUM_REQ; retry=0 -> S_RELEASE.
//   S_RELEASE : wait iReq[g]==0, then drop oGrant -> S_IDLE (four-phase handshake).
//  Latency: iReq rise -> oStrobe_to_phy = 2 cycles; iStrobe_from_phy -> oDone = 2 cycles.
//  oError clears at next S_ARB; oResponse on error = all zeros.
//  iReq changes on non-granted lines during a transaction: ignored until S_IDLE.
//  Granted line drops iReq before S_DONE: transaction still completes, S_RELEASE exits immediately.
//  iStrobe_from_phy/iTimeout_from_phy outside S_WAIT: ignored.
//  Counters saturate; watchdog 8 bits min, retry clog2(MAX_RETRY+1) bits.
// STRUCTURE
//  Header sd_cmd_defs.vh: state encodings S_*, CMD_W default, shared with other command-layer blocks.
//  Sub-module sd_rr_arbiter: combinational pick of iReq vs pointer -> one-hot + index; pointer register stays in scheduler.
// TESTING
//  T1 single req: iReq=01, cmd=48'h40_0000_0000_95; phy responds 10 cycles later -> strobe at +2, oAck, oDone=01, oResponse matches.
//  T2 contention: iReq=11 from idle, ptr=0 -> req0 served first, then req1; repeat -> req1 first (ptr=1).
//  T3 retry: phy timeout twice then responds -> 3 strobes, gaps of 4 cycles, oDone with oError=0.
//  T4 exhaust: phy timeout 3 times -> oDone, oError=1, oResponse=0, no oAck_to_phy.
//  T5 watchdog: phy silent -> oIdle_to_phy pulse at 128 cycles into S_WAIT, oError=1.
//  T6 reset in S_WAIT, then response + timeout same cycle after new issue -> clean restart; response path taken.

Source files
------------

// File: rtl/sd_cmd_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// sd_cmd_scheduler_pkg
// Shared definitions for the SD command-channel scheduler: FSM state encoding,
// default widths and small constant helpers used to size counters and to
// advance the round-robin pointer.
// -----------------------------------------------------------------------------
package sd_cmd_scheduler_pkg;

    // Default SD command / response width (48-bit command tokens).
    localparam int DEF_CMD_W = 48;

    // The watchdog counter is never narrower than this.
    localparam int WD_MIN_W = 8;

    // Scheduler states, one transition per clock.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_GAP     = 3'd4,
        S_ACK     = 3'd5,
        S_DONE    = 3'd6,
        S_RELEASE = 3'd7
    } sched_state_e;

    // Bits needed to count 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Next round-robin index after idx, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/sd_cmd_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sd_cmd_scheduler_rr_arbiter
// Purely combinational round-robin pick: the first asserted request at or
// after the pointer position (wrapping) wins. The pointer register itself is
// owned by the scheduler.
// Ports:
//   req_i    in  NUM_REQ  request levels
//   ptr_i    in  PTR_W    index of highest-priority requester
//   gnt_o    out NUM_REQ  one-hot winner (all zero when no request)
//   idx_o    out PTR_W    binary index of the winner
//   valid_o  out 1        at least one request present
// -----------------------------------------------------------------------------
module sd_cmd_scheduler_rr_arbiter
    import sd_cmd_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [NUM_REQ-1:0] gnt_s;
    logic [PTR_W-1:0]   idx_s;
    logic               found_s;
    logic [NUM_REQ-1:0] cand_mask_s;
    int                 cand_s;

    // Walk the requesters starting at the pointer; the first hit is latched.
    always_comb begin
        gnt_s       = '0;
        idx_s       = '0;
        found_s     = 1'b0;
        cand_mask_s = '0;
        cand_s      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s      = (int'(ptr_i) + i) % NUM_REQ;
            cand_mask_s = NUM_REQ'(1'b1) << cand_s;
            if (!found_s && ((req_i & cand_mask_s) != '0)) begin
                gnt_s   = cand_mask_s;
                idx_s   = PTR_W'(cand_s);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign gnt_o   = gnt_s;
    assign idx_o   = idx_s;
    assign valid_o = found_s;

endmodule

// File: rtl/sd_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// sd_cmd_scheduler
// Shares the SD physical command channel between NUM_REQ requesters. A
// round-robin winner's command is latched and strobed to the phy; the
// response (or timeout) is collected, timed-out commands are re-issued up to
// MAX_RETRY times after RETRY_GAP idle cycles, and a local watchdog aborts a
// silent phy. The result is returned to the granted requester with a
// one-cycle oDone pulse and the grant is held until that requester drops its
// request (four-phase handshake). All outputs are registered.
// Ports:
//   iClock_SD / iReset           clock, synchronous active-high reset
//   iReq, iCommand_bus           requester levels and packed commands
//   oGrant, oDone                one-hot grant, one-cycle completion pulse
//   oResponse, oError            result of the completed transaction
//   oStrobe_to_phy, oCommand_to_phy   command issue to phy
//   iStrobe_from_phy, iResponse_from_phy, iTimeout_from_phy  phy result
//   oAck_to_phy, oIdle_to_phy    response acknowledge, watchdog force-idle
// -----------------------------------------------------------------------------
module sd_cmd_scheduler
    import sd_cmd_scheduler_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int CMD_W     = DEF_CMD_W,
    parameter int MAX_RETRY = 2,
    parameter int RETRY_GAP = 4,
    parameter int WATCHDOG  = 128
) (
    input  logic                     iClock_SD,
    input  logic                     iReset,
    input  logic [NUM_REQ-1:0]       iReq,
    input  logic [NUM_REQ*CMD_W-1:0] iCommand_bus,
    output logic [NUM_REQ-1:0]       oGrant,
    output logic [NUM_REQ-1:0]       oDone,
    output logic [CMD_W-1:0]         oResponse,
    output logic                     oError,
    output logic                     oStrobe_to_phy,
    output logic [CMD_W-1:0]         oCommand_to_phy,
    input  logic                     iStrobe_from_phy,
    input  logic [CMD_W-1:0]         iResponse_from_phy,
    input  logic                     iTimeout_from_phy,
    output logic                     oAck_to_phy,
    output logic                     oIdle_to_phy
);

    localparam int PTR_W   = clog2_min1(NUM_REQ);
    localparam int RETRY_W = clog2_min1(MAX_RETRY + 1);
    localparam int GAP_W   = clog2_min1(RETRY_GAP);
    localparam int WD_W    = (clog2_min1(WATCHDOG) > WD_MIN_W) ? clog2_min1(WATCHDOG) : WD_MIN_W;

    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);
    localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'(RETRY_GAP - 1);
    localparam logic [GAP_W-1:0]   GAP_ONE     = GAP_W'(1);
    localparam logic [WD_W-1:0]    WD_LAST     = WD_W'(WATCHDOG - 1);
    localparam logic [WD_W-1:0]    WD_ONE      = WD_W'(1);

    sched_state_e         state_q,     state_d;
    logic [NUM_REQ-1:0]   grant_q,     grant_d;
    logic [PTR_W-1:0]     gidx_q,      gidx_d;
    logic [PTR_W-1:0]     ptr_q,       ptr_d;
    logic [NUM_REQ-1:0]   done_q,      done_d;
    logic                 error_q,     error_d;
    logic [CMD_W-1:0]     resp_q,      resp_d;
    logic [CMD_W-1:0]     phy_resp_q,  phy_resp_d;
    logic                 strobe_q,    strobe_d;
    logic [CMD_W-1:0]     cmd_q,       cmd_d;
    logic                 ack_q,       ack_d;
    logic                 idle_q,      idle_d;
    logic [RETRY_W-1:0]   retry_q,     retry_d;
    logic [WD_W-1:0]      wd_q,        wd_d;
    logic [GAP_W-1:0]     gap_q,       gap_d;

    logic [NUM_REQ-1:0]   arb_gnt_s;
    logic [PTR_W-1:0]     arb_idx_s;
    logic                 arb_valid_s;
    logic [CMD_W-1:0]     cmd_sel_s;

    sd_cmd_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i   (iReq),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt_s),
        .idx_o   (arb_idx_s),
        .valid_o (arb_valid_s)
    );

    // One-hot AND-OR mux selecting the arbitration winner's command.
    always_comb begin
        cmd_sel_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cmd_sel_s = cmd_sel_s | ({CMD_W{arb_gnt_s[k]}} & iCommand_bus[k*CMD_W +: CMD_W]);
        end
    end

    // Next-state and registered-output logic; pulse outputs default low.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        done_d     = '0;
        error_d    = error_q;
        resp_d     = resp_q;
        phy_resp_d = phy_resp_q;
        strobe_d   = 1'b0;
        cmd_d      = cmd_q;
        ack_d      = 1'b0;
        idle_d     = 1'b0;
        retry_d    = retry_q;
        wd_d       = wd_q;
        gap_d      = gap_q;

        case (state_q)
            S_IDLE: begin
                if (iReq != '0) begin
                    state_d = S_ARB;
                    error_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARB: begin
                // A request that vanished between IDLE and ARB just returns to idle.
                if (arb_valid_s) begin
                    grant_d  = arb_gnt_s;
                    gidx_d   = arb_idx_s;
                    cmd_d    = cmd_sel_s;
                    retry_d  = '0;
                    strobe_d = 1'b1;
                    state_d  = S_ISSUE;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response arriving with a timeout in the same cycle wins.
                if (iStrobe_from_phy) begin
                    phy_resp_d = iResponse_from_phy;
                    ack_d      = 1'b1;
                    state_d    = S_ACK;
                end else if (iTimeout_from_phy) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + RETRY_ONE;
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        error_d = 1'b1;
                        resp_d  = '0;
                        done_d  = grant_q;
                        state_d = S_DONE;
                    end
                end else if (wd_q == WD_LAST) begin
                    idle_d  = 1'b1;
                    error_d = 1'b1;
                    resp_d  = '0;
                    done_d  = grant_q;
                    state_d = S_DONE;
                end else begin
                    wd_d    = wd_q + WD_ONE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    strobe_d = 1'b1;
                    state_d  = S_ISSUE;
                end else begin
                    gap_d    = gap_q + GAP_ONE;
                end
            end
            S_ACK: begin
                error_d = 1'b0;
                resp_d  = phy_resp_q;
                done_d  = grant_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                ptr_d   = PTR_W'(rr_next(int'(gidx_q), NUM_REQ));
                retry_d = '0;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if ((iReq & grant_q) == '0) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge iClock_SD) begin
        if (iReset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            ptr_q      <= '0;
            done_q     <= '0;
            error_q    <= 1'b0;
            resp_q     <= '0;
            phy_resp_q <= '0;
            strobe_q   <= 1'b0;
            cmd_q      <= '0;
            ack_q      <= 1'b0;
            idle_q     <= 1'b0;
            retry_q    <= '0;
            wd_q       <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            ptr_q      <= ptr_d;
            done_q     <= done_d;
            error_q    <= error_d;
            resp_q     <= resp_d;
            phy_resp_q <= phy_resp_d;
            strobe_q   <= strobe_d;
            cmd_q      <= cmd_d;
            ack_q      <= ack_d;
            idle_q     <= idle_d;
            retry_q    <= retry_d;
            wd_q       <= wd_d;
            gap_q      <= gap_d;
        end
    end

    assign oGrant          = grant_q;
    assign oDone           = done_q;
    assign oResponse       = resp_q;
    assign oError          = error_q;
    assign oStrobe_to_phy  = strobe_q;
    assign oCommand_to_phy = cmd_q;
    assign oAck_to_phy     = ack_q;
    assign oIdle_to_phy    = idle_q;

endmodule

// File: tb/tb_sd_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sd_cmd_scheduler
// Directed bench for sd_cmd_scheduler: single request, round-robin contention,
// retry, retry exhaustion, watchdog abort, and reset mid-transaction.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sd_cmd_scheduler;

    logic         iClock_SD = 1'b0;
    logic         iReset;
    logic [1:0]   iReq;
    logic [95:0]  iCommand_bus;
    logic [1:0]   oGrant;
    logic [1:0]   oDone;
    logic [47:0]  oResponse;
    logic         oError;
    logic         oStrobe_to_phy;
    logic [47:0]  oCommand_to_phy;
    logic         iStrobe_from_phy;
    logic [47:0]  iResponse_from_phy;
    logic         iTimeout_from_phy;
    logic         oAck_to_phy;
    logic         oIdle_to_phy;

    int n_checks = 0;
    int n_errors = 0;
    int ack_pulses = 0;

    localparam logic [47:0] CMD0 = 48'h40_0000_0000_95;
    localparam logic [47:0] CMD1 = 48'h51_1234_5678_AB;

    sd_cmd_scheduler #(
        .NUM_REQ   (2),
        .CMD_W     (48),
        .MAX_RETRY (2),
        .RETRY_GAP (4),
        .WATCHDOG  (128)
    ) dut (
        .iClock_SD          (iClock_SD),
        .iReset             (iReset),
        .iReq               (iReq),
        .iCommand_bus       (iCommand_bus),
        .oGrant             (oGrant),
        .oDone              (oDone),
        .oResponse          (oResponse),
        .oError             (oError),
        .oStrobe_to_phy     (oStrobe_to_phy),
        .oCommand_to_phy    (oCommand_to_phy),
        .iStrobe_from_phy   (iStrobe_from_phy),
        .iResponse_from_phy (iResponse_from_phy),
        .iTimeout_from_phy  (iTimeout_from_phy),
        .oAck_to_phy        (oAck_to_phy),
        .oIdle_to_phy       (oIdle_to_phy)
    );

    always #5 iClock_SD = ~iClock_SD;

    // Count phy acknowledge pulses.
    always @(posedge iClock_SD) begin
        if (oAck_to_phy) ack_pulses <= ack_pulses + 1;
    end

    // Absolute time limit.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge iClock_SD);
    endtask

    task automatic phy_respond(input logic [47:0] rsp, input logic with_timeout);
        iStrobe_from_phy   = 1'b1;
        iResponse_from_phy = rsp;
        iTimeout_from_phy  = with_timeout;
        step(1);
        iStrobe_from_phy   = 1'b0;
        iTimeout_from_phy  = 1'b0;
        iResponse_from_phy = '0;
    endtask

    task automatic phy_timeout();
        iTimeout_from_phy = 1'b1;
        step(1);
        iTimeout_from_phy = 1'b0;
    endtask

    // sel 0: wait for oStrobe_to_phy, sel 1: wait for oIdle_to_phy; n=-1 if never seen.
    task automatic wait_pulse(input int sel, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step(1);
            if ((sel == 0) ? oStrobe_to_phy : oIdle_to_phy) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic release_req(input logic [1:0] mask, input string tag);
        iReq = iReq & ~mask;
        step(2);
        chk({tag, "_grant_drop"}, oGrant, 2'b00);
    endtask

    task automatic do_reset();
        iReset = 1'b1;
        step(3);
        iReset = 1'b0;
    endtask

    // Full successful transaction from idle with iReq already driven.
    task automatic transact(input logic [1:0] g, input logic [47:0] cmd,
                            input logic [47:0] rsp, input string tag);
        step(2);
        chk({tag, "_strobe"}, oStrobe_to_phy, 1'b1);
        chk({tag, "_grant"}, oGrant, g);
        chk({tag, "_cmd"}, oCommand_to_phy, cmd);
        step(4);
        phy_respond(rsp, 1'b0);
        step(1);
        chk({tag, "_done"}, oDone, g);
        chk({tag, "_resp"}, oResponse, rsp);
        chk({tag, "_err"}, oError, 1'b0);
        release_req(g, tag);
    endtask

    int n;
    int acks_before;

    initial begin
        iReset = 1'b1; iReq = '0; iCommand_bus = {CMD1, CMD0};
        iStrobe_from_phy = 1'b0; iResponse_from_phy = '0; iTimeout_from_phy = 1'b0;
        step(3);
        chk("rst_grant", oGrant, 2'b00);
        chk("rst_done", oDone, 2'b00);
        chk("rst_strobe", oStrobe_to_phy, 1'b0);
        chk("rst_cmd", oCommand_to_phy, 48'h0);
        chk("rst_err_idle_ack", {oError, oIdle_to_phy, oAck_to_phy}, 3'b000);
        iReset = 1'b0;

        // T1: single requester, phy answers 10 cycles after the strobe.
        iReq = 2'b01;
        step(1);
        chk("t1_strobe_early", oStrobe_to_phy, 1'b0);
        step(1);
        chk("t1_strobe", oStrobe_to_phy, 1'b1);
        chk("t1_cmd", oCommand_to_phy, CMD0);
        chk("t1_grant", oGrant, 2'b01);
        step(1);
        chk("t1_strobe_1cyc", oStrobe_to_phy, 1'b0);
        step(9);
        phy_respond(48'h3F_0000_0900_01, 1'b0);
        chk("t1_ack", oAck_to_phy, 1'b1);
        chk("t1_done_early", oDone, 2'b00);
        step(1);
        chk("t1_done", oDone, 2'b01);
        chk("t1_resp", oResponse, 48'h3F_0000_0900_01);
        chk("t1_ack_1cyc", oAck_to_phy, 1'b0);
        step(1);
        chk("t1_done_1cyc", oDone, 2'b00);
        chk("t1_grant_held", oGrant, 2'b01);
        release_req(2'b01, "t1");

        // T2a: pointer now 1, both request -> req1 first, then req0.
        iReq = 2'b11;
        transact(2'b10, CMD1, 48'hA1A1_0000_0001, "t2a_r1");
        transact(2'b01, CMD0, 48'hB2B2_0000_0002, "t2a_r0");

        // T2b: after reset pointer is 0 -> req0 first, then req1.
        do_reset();
        iReq = 2'b11;
        transact(2'b01, CMD0, 48'hC3C3_0000_0003, "t2b_r0");
        transact(2'b10, CMD1, 48'hD4D4_0000_0004, "t2b_r1");

        // T3: two timeouts then a response; pointer 0 so req0 alone.
        iReq = 2'b01;
        step(2);
        chk("t3_strobe1", oStrobe_to_phy, 1'b1);
        step(3);
        phy_timeout();
        wait_pulse(0, 20, n);
        chk("t3_gap1", n, 4);
        step(3);
        phy_timeout();
        wait_pulse(0, 20, n);
        chk("t3_gap2", n, 4);
        chk("t3_cmd_reissue", oCommand_to_phy, CMD0);
        step(3);
        phy_respond(48'h1234_5678_9ABC, 1'b0);
        chk("t3_ack", oAck_to_phy, 1'b1);
        step(1);
        chk("t3_done", oDone, 2'b01);
        chk("t3_err", oError, 1'b0);
        chk("t3_resp", oResponse, 48'h1234_5678_9ABC);
        release_req(2'b01, "t3");

        // T4: three timeouts exhaust the retries.
        acks_before = ack_pulses;
        iReq = 2'b01;
        step(2);
        step(2);
        phy_timeout();
        wait_pulse(0, 20, n);
        step(2);
        phy_timeout();
        wait_pulse(0, 20, n);
        chk("t4_third_strobe", n, 4);
        step(2);
        phy_timeout();
        chk("t4_done", oDone, 2'b01);
        chk("t4_err", oError, 1'b1);
        chk("t4_resp_zero", oResponse, 48'h0);
        chk("t4_no_ack", ack_pulses, acks_before);
        release_req(2'b01, "t4");

        // T5: silent phy -> watchdog abort 128 cycles into the wait.
        iReq = 2'b01;
        step(1);
        chk("t5_err_cleared", oError, 1'b0);
        step(1);
        chk("t5_strobe", oStrobe_to_phy, 1'b1);
        step(1);
        wait_pulse(1, 200, n);
        chk("t5_wd_cycles", n, 128);
        chk("t5_err", oError, 1'b1);
        chk("t5_done", oDone, 2'b01);
        step(1);
        chk("t5_idle_1cyc", oIdle_to_phy, 1'b0);
        release_req(2'b01, "t5");

        // T6: reset while waiting, then response and timeout together.
        iReq = 2'b01;
        step(4);
        iReset = 1'b1;
        step(1);
        chk("t6_rst_grant", oGrant, 2'b00);
        chk("t6_rst_cmd", oCommand_to_phy, 48'h0);
        chk("t6_rst_done", oDone, 2'b00);
        iReset = 1'b0;
        step(2);
        chk("t6_restart_strobe", oStrobe_to_phy, 1'b1);
        step(3);
        phy_respond(48'h5555_AAAA_0F0F, 1'b1);
        chk("t6_ack", oAck_to_phy, 1'b1);
        step(1);
        chk("t6_done", oDone, 2'b01);
        chk("t6_err", oError, 1'b0);
        chk("t6_resp", oResponse, 48'h5555_AAAA_0F0F);
        release_req(2'b01, "t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
